// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code sequence generator: state encoding,
// default width and a reference binary-to-Gray helper.
package gray_pkg;

  localparam int GRAY_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Full-width helper; callers narrower than 16 bits zero-extend and truncate.
  function automatic logic [15:0] bin2gray(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_cnt_bin2gray.sv
// Combinational W-bit binary-to-Gray encoder, the counterpart of the
// downstream gray_bin converter.
module bin2gray #(
  parameter int W = 4
) (
  input  logic [W-1:0] b,
  output logic [W-1:0] g
);

  // Each Gray bit is the XOR of a binary bit and its upper neighbour.
  always_comb begin
    g = b ^ (b >> 1);
  end

endmodule

// File: rtl/gray_cnt.sv
// Gray-code sequence generator with valid/ready output handshake, up/down
// direction, wrap or one-shot termination and a binary preload.
module gray_cnt
  import gray_pkg::*;
#(
  parameter int W = GRAY_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         up_dn,
  input  logic         one_shot,
  input  logic         ready,
  output logic [W-1:0] g,
  output logic         valid,
  output logic         tc,
  output logic         busy
);

  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
  localparam logic [W-1:0] ALL_ZERO = {W{1'b0}};
  localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};

  state_e       state_r, state_nxt_s;
  logic [W-1:0] cnt_r, cnt_nxt_s;
  logic         dir_r, dir_nxt_s;
  logic         os_r, os_nxt_s;
  logic         pend_r, pend_nxt_s;
  logic [W-1:0] term_s, term_nxt_s;
  logic [W-1:0] g_nxt_s;
  logic         xfer_s;
  logic         valid_nxt_s, tc_nxt_s;
  logic [W-1:0] g_r;
  logic         valid_r, tc_r, busy_r;

  // Transfer and terminal code for the word currently on offer.
  always_comb begin
    xfer_s = (state_r == RUN) && ready;
    if (dir_r) begin
      term_s = ALL_ONES;
    end else begin
      term_s = ALL_ZERO;
    end
  end

  // Next-state logic; a one-shot terminal transfer to DONE outranks a pending stop.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    dir_nxt_s   = dir_r;
    os_nxt_s    = os_r;
    pend_nxt_s  = pend_r;
    case (state_r)
      IDLE, DONE: begin
        pend_nxt_s = 1'b0;
        if (load) begin
          cnt_nxt_s = load_val;
        end else begin
          cnt_nxt_s = cnt_r;
        end
        if (start) begin
          state_nxt_s = RUN;
          dir_nxt_s   = up_dn;
          os_nxt_s    = one_shot;
        end else begin
          state_nxt_s = state_r;
        end
      end
      RUN: begin
        pend_nxt_s = pend_r | stop;
        if (xfer_s) begin
          if (os_r && (cnt_r == term_s)) begin
            state_nxt_s = DONE;
            pend_nxt_s  = 1'b0;
          end else begin
            if (dir_r) begin
              cnt_nxt_s = cnt_r + ONE;
            end else begin
              cnt_nxt_s = cnt_r - ONE;
            end
            if (pend_r || stop) begin
              state_nxt_s = IDLE;
              pend_nxt_s  = 1'b0;
            end else begin
              state_nxt_s = RUN;
            end
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        pend_nxt_s  = 1'b0;
      end
    endcase
  end

  bin2gray #(.W(W)) u_enc (
    .b (cnt_nxt_s),
    .g (g_nxt_s)
  );

  // Output values for the next cycle, so every port comes straight from a flop.
  always_comb begin
    if (dir_nxt_s) begin
      term_nxt_s = ALL_ONES;
    end else begin
      term_nxt_s = ALL_ZERO;
    end
    valid_nxt_s = (state_nxt_s == RUN);
    tc_nxt_s    = valid_nxt_s && (cnt_nxt_s == term_nxt_s);
  end

  // State, count, latched modes and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= ALL_ZERO;
      dir_r   <= 1'b0;
      os_r    <= 1'b0;
      pend_r  <= 1'b0;
      g_r     <= ALL_ZERO;
      valid_r <= 1'b0;
      tc_r    <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      dir_r   <= dir_nxt_s;
      os_r    <= os_nxt_s;
      pend_r  <= pend_nxt_s;
      g_r     <= g_nxt_s;
      valid_r <= valid_nxt_s;
      tc_r    <= tc_nxt_s;
      busy_r  <= valid_nxt_s;
    end
  end

  assign g     = g_r;
  assign valid = valid_r;
  assign tc    = tc_r;
  assign busy  = busy_r;

endmodule
